// File: rtl/ctrl_pkg.sv
// Purpose: shared opcode, ALU-operation and FSM-state encodings for the multicycle control unit.
// Latency: n/a (constants, types and one combinational helper).
// Backpressure: n/a.
package ctrl_pkg;

  // Register-register opcodes; destination is rd.
  localparam logic [5:0] OP_ADD  = 6'b000000;
  localparam logic [5:0] OP_SUB  = 6'b000001;
  localparam logic [5:0] OP_AND  = 6'b000010;
  localparam logic [5:0] OP_OR   = 6'b000011;
  localparam logic [5:0] OP_XOR  = 6'b000100;
  localparam logic [5:0] OP_SLT  = 6'b000101;

  // Immediate opcodes; destination is rt, operand B is the extended immediate.
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_ANDI = 6'b001100;
  localparam logic [5:0] OP_ORI  = 6'b001101;

  typedef enum logic [2:0] {
    ALU_ADD = 3'd0,
    ALU_SUB = 3'd1,
    ALU_AND = 3'd2,
    ALU_OR  = 3'd3,
    ALU_XOR = 3'd4,
    ALU_SLT = 3'd5
  } alu_op_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_DECODE    = 2'd1,
    ST_EXECUTE   = 2'd2,
    ST_WRITEBACK = 2'd3
  } state_t;

  // Legal ALU latency range; the counter is sized to hold ALU_LAT_MAX-1.
  localparam int ALU_LAT_MIN = 1;
  localparam int ALU_LAT_MAX = 15;
  localparam int LAT_CNT_W   = 4;

  function automatic logic [31:0] extend_imm(input logic [15:0] imm16, input logic sign_ext);
    return sign_ext ? {{16{imm16[15]}}, imm16} : {16'h0000, imm16};
  endfunction

endpackage

// File: rtl/ctrl_decoder.sv
// Purpose: combinational opcode decoder producing ALU op, destination select, immediate select/extension and legality.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; output follows the opcode input.
// Ports: opcode (6) in; alu_op (3), dest_rt, imm_sel, sign_ext, legal out.
module ctrl_decoder
  import ctrl_pkg::*;
#(
  parameter int ENABLE_IMM = 1
) (
  input  logic [5:0] opcode,
  output alu_op_t    alu_op,
  output logic       dest_rt,
  output logic       imm_sel,
  output logic       sign_ext,
  output logic       legal
);

  localparam logic IMM_ON = (ENABLE_IMM != 0);

  always_comb begin
    alu_op   = ALU_ADD;
    dest_rt  = 1'b0;
    imm_sel  = 1'b0;
    sign_ext = 1'b0;
    legal    = 1'b1;
    case (opcode)
      OP_ADD:  alu_op = ALU_ADD;
      OP_SUB:  alu_op = ALU_SUB;
      OP_AND:  alu_op = ALU_AND;
      OP_OR:   alu_op = ALU_OR;
      OP_XOR:  alu_op = ALU_XOR;
      OP_SLT:  alu_op = ALU_SLT;
      OP_ADDI: begin
        alu_op   = ALU_ADD;
        dest_rt  = 1'b1;
        imm_sel  = 1'b1;
        sign_ext = 1'b1;
        legal    = IMM_ON;
      end
      OP_ANDI: begin
        alu_op  = ALU_AND;
        dest_rt = 1'b1;
        imm_sel = 1'b1;
        legal   = IMM_ON;
      end
      OP_ORI: begin
        alu_op  = ALU_OR;
        dest_rt = 1'b1;
        imm_sel = 1'b1;
        legal   = IMM_ON;
      end
      default: legal = 1'b0;
    endcase

    // A disabled I-type opcode is reported like any other illegal one,
    // so none of its opcode-specific fields should leak out.
    if (!legal) begin
      alu_op   = ALU_ADD;
      dest_rt  = 1'b0;
      imm_sel  = 1'b0;
      sign_ext = 1'b0;
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Purpose: multicycle control unit; accepts one instruction, decodes it, drives the ALU for ALU_LAT cycles, then writes back.
// Latency: accept at edge T -> DECODE T+1, EXECUTE T+2..T+1+ALU_LAT, WRITEBACK (we) T+2+ALU_LAT; illegal pulses at T+1.
// Backpressure: instr_ready high only in IDLE or WRITEBACK; a held instr_valid is taken in WRITEBACK for back-to-back issue.
// Ports: clk, rst (sync, active high); instr_valid/instruction/instr_ready handshake;
//        alu_enable, alu_op, rs_addr, rt_addr, addr, imm_sel, imm, we, illegal, busy outputs.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int ALU_LAT    = 1,
  parameter int ENABLE_IMM = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        instr_valid,
  input  logic [31:0] instruction,
  output logic        instr_ready,
  output logic        alu_enable,
  output logic [2:0]  alu_op,
  output logic [4:0]  rs_addr,
  output logic [4:0]  rt_addr,
  output logic [4:0]  addr,
  output logic        imm_sel,
  output logic [31:0] imm,
  output logic        we,
  output logic        illegal,
  output logic        busy
);

  if (ALU_LAT < ALU_LAT_MIN || ALU_LAT > ALU_LAT_MAX) begin : g_bad_alu_lat
    $error("multicycle_control_unit: ALU_LAT out of range 1..15");
  end

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(ALU_LAT - 1);

  state_t                 state;
  logic [LAT_CNT_W-1:0]   lat_cnt;
  logic                   legal_q;
  logic                   accept;

  alu_op_t                dec_alu_op;
  logic                   dec_dest_rt;
  logic                   dec_imm_sel;
  logic                   dec_sign_ext;
  logic                   dec_legal;

  // Decoding the incoming word at the accept edge lets every decoded field
  // be registered and visible during the DECODE cycle itself.
  ctrl_decoder #(
    .ENABLE_IMM (ENABLE_IMM)
  ) u_decoder (
    .opcode   (instruction[31:26]),
    .alu_op   (dec_alu_op),
    .dest_rt  (dec_dest_rt),
    .imm_sel  (dec_imm_sel),
    .sign_ext (dec_sign_ext),
    .legal    (dec_legal)
  );

  assign instr_ready = (state == ST_IDLE) || (state == ST_WRITEBACK);
  assign accept      = instr_valid && instr_ready;
  assign busy        = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      lat_cnt    <= '0;
      legal_q    <= 1'b0;
      alu_enable <= 1'b0;
      alu_op     <= '0;
      rs_addr    <= '0;
      rt_addr    <= '0;
      addr       <= '0;
      imm_sel    <= 1'b0;
      imm        <= '0;
      we         <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      illegal <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (instr_valid) state <= ST_DECODE;
        end
        ST_DECODE: begin
          if (legal_q) begin
            lat_cnt    <= LAT_LOAD;
            alu_enable <= 1'b1;
            state      <= ST_EXECUTE;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_EXECUTE: begin
          if (lat_cnt == '0) begin
            alu_enable <= 1'b0;
            // Register 0 is hard-wired; never write it.
            we         <= (addr != 5'd0);
            state      <= ST_WRITEBACK;
          end else begin
            lat_cnt <= lat_cnt - 1'b1;
          end
        end
        ST_WRITEBACK: begin
          we    <= 1'b0;
          state <= instr_valid ? ST_DECODE : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (accept) begin
        legal_q <= dec_legal;
        illegal <= !dec_legal;
        alu_op  <= dec_alu_op;
        rs_addr <= instruction[25:21];
        rt_addr <= instruction[20:16];
        addr    <= dec_dest_rt ? instruction[20:16] : instruction[15:11];
        imm_sel <= dec_imm_sel;
        imm     <= extend_imm(instruction[15:0], dec_sign_ext);
      end
    end
  end

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

- Multi-cycle, parametrised successor to the single-cycle control unit.
- Accepts one 32-bit instruction at a time over a valid/ready handshake, decodes it into registered operand, destination and ALU-operation fields, then sequences execute and writeback phases.
- Adds subtract-style and immediate (I-type) operations, a configurable ALU latency, illegal-opcode reporting and suppression of writes to register 0.
- Sits between the instruction source and the ALU/register file.

## Interface
Parameters:
- ALU_LAT, 1 — cycles `alu_enable` is held per instruction; legal range 1..15.
- ENABLE_IMM, 1 — 1: I-type opcodes are legal; 0: they are flagged illegal.

Ports:
- clk  in  1  — single clock; all state updates on the rising edge.
- rst  in  1  — synchronous, active-high reset.
- instr_valid  in  1  — instruction present on `instruction`.
- instruction  in  32  — [31:26] opcode, [25:21] rs, [20:16] rt, [15:11] rd, [15:0] imm.
- instr_ready  out  1  — unit can accept; combinational, high in IDLE or WRITEBACK.
- alu_enable  out  1  — high for exactly ALU_LAT cycles per legal instruction.
- alu_op  out  3  — 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT.
- rs_addr  out  5  — source register 1.
- rt_addr  out  5  — source register 2.
- addr  out  5  — destination register.
- imm_sel  out  1  — 1: ALU operand B is `imm`, not the value read from rt.
- imm  out  32  — extended immediate.
- we  out  1  — register-file write enable; single-cycle pulse.
- illegal  out  1  — single-cycle pulse on an undecodable opcode.
- busy  out  1  — state is not IDLE.

## Operation
Opcode map:
- 000000 ADD, 000001 SUB, 000010 AND, 000011 OR, 000100 XOR, 000101 SLT.
  - Destination is rd; `imm_sel` = 0.
- With ENABLE_IMM = 1:
  - 001000 ADDI: imm is sign-extended.
  - 001100 ANDI: imm is zero-extended.
  - 001101 ORI: imm is zero-extended.
  - For all three: destination is rt, `imm_sel` = 1, `alu_op` = ADD/AND/OR respectively.
- Any other opcode, or an I-type opcode with ENABLE_IMM = 0, is illegal.

States: IDLE, DECODE, EXECUTE, WRITEBACK.
- IDLE: if `instr_valid`, capture `instruction` and go to DECODE.
- DECODE: register all decoded outputs.
  - Illegal opcode: pulse `illegal`, go to IDLE.
  - Legal opcode: load the latency counter with ALU_LAT−1 and go to EXECUTE.
- EXECUTE: `alu_enable` = 1. Decrement the counter; when it reaches 0, go to WRITEBACK.
- WRITEBACK:
  - `we` = 1 for this cycle only if `addr` ≠ 0.
  - If `instr_valid` is also high, capture the new instruction and go to DECODE; otherwise go to IDLE.

Output holding:
- `rs_addr`, `rt_addr`, `addr`, `alu_op`, `imm_sel` and `imm` hold from DECODE until the next DECODE.
- On an illegal instruction, these fields still update (opcode-independent fields decoded normally). `we` and `alu_enable` are never asserted for it.

Reset:
- All outputs reset to 0, state to IDLE, counter to 0; `instr_ready` = 1 after reset.
- Reset mid-operation: the instruction is dropped, no `we` is issued, and the state returns to IDLE.

## Timing
Instruction accepted on edge T:
- DECODE occupies cycle T+1.
- EXECUTE occupies cycles T+2 .. T+1+ALU_LAT.
- WRITEBACK (`we`) occurs in cycle T+2+ALU_LAT.
- Back-to-back issue period is ALU_LAT+2 cycles, because acceptance overlaps WRITEBACK.

Illegal instruction accepted on edge T:
- `illegal` pulses in cycle T+1.
- `instr_ready` is high again in cycle T+2.

Handshake:
- Transfer occurs only when `instr_valid && instr_ready` at a rising edge.
- `instruction` is sampled only at that edge.
- `instr_valid` while not ready is held by the source; the unit does not drop it.

## Structure
- `ctrl_pkg` holds:
  - opcode localparams;
  - the `alu_op` encodings;
  - the state encoding (2-bit);
  - the ALU_LAT range check constant.
- Sub-module `ctrl_decoder` is purely combinational. It maps opcode and ENABLE_IMM to alu_op, dest_sel (rd/rt), imm_sel, sign_ext and legal.
- The top level holds the FSM, the latency counter and the output registers.

## Test plan
- **Reset:** assert `rst` 2 cycles with `instr_valid` = 1 → all outputs 0, `instr_ready` = 1, no capture.
- **ADD, ALU_LAT = 1:** ADD rs=1, rt=2, rd=3 (0x00221800) accepted at T → `alu_op` = 0, `addr` = 3 in T+1; `alu_enable` in T+2; `we` in T+3.
- **ADDI with negative immediate, ALU_LAT = 3:** ADDI rt=4, imm=0xFFF0 → `addr` = 4, `imm` = 0xFFFFFFF0, `imm_sel` = 1; `alu_enable` held 3 cycles; `we` at T+5. ORI imm=0x8000 → `imm` = 0x00008000.
- **Illegal opcodes:** opcode 0x3F → `illegal` pulse at T+1, no `alu_enable`/`we`. With ENABLE_IMM = 0, ADDI → illegal.
- **Write to register 0:** ADD with rd = 0 → `alu_enable` asserted, `we` stays 0. Back-to-back SUB held valid during WRITEBACK → accepted in WRITEBACK; issue period is 3 cycles (ALU_LAT = 1).
- **Reset mid-EXECUTE:** ALU_LAT = 4, reset in the 2nd execute cycle → next cycle IDLE, `we` never pulses.
